// File: rtl/stage_mem_if.sv
// Data-memory bus between the MEM stage and the 32-bit data memory.
// Read data is synchronous: valid the cycle after dmem_re.
interface stage_mem_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_addr, dmem_wdata, dmem_we, dmem_re, dmem_size,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_we, dmem_re, dmem_size,
    output dmem_rdata
  );
endinterface

// File: rtl/stage_mem.sv
// MEM stage: scalar accesses pass straight through to data memory; matrix
// loads/stores are split into LANES word beats while upstream is stalled.
module stage_mem #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [31:0]           me_alu_o,
  input  logic [31:0]           me_regs_data2,
  input  logic [32*LANES-1:0]   me_matrix_o,
  input  logic                  me_mem_read,
  input  logic                  me_mem_write,
  input  logic [1:0]            me_w_select,
  input  logic [2:0]            me_func3_code,
  stage_mem_if.master           mem_bus,
  output logic [31:0]           mem_load_o,
  output logic [32*LANES-1:0]   mem_matrix_o,
  output logic                  mem_matrix_vld,
  output logic                  mem_stall
);

  typedef enum logic [1:0] {IDLE, MLOAD, MSTORE, MDONE} state_e;

  localparam logic [2:0] CNT_LAST_LD = 3'(LANES);
  localparam logic [2:0] CNT_LAST_ST = 3'(LANES - 1);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:2]           base_q, base_d;
  logic [32*LANES-1:0]   buf_q, buf_d;
  logic [32*LANES-1:0]   matrix_q, matrix_d;

  logic        m_st, m_ld;
  logic [31:0] beat_addr;

  // Store wins when both strobes are set on a matrix access.
  assign m_st      = me_mem_write && (me_w_select == 2'b11);
  assign m_ld      = me_mem_read  && (me_w_select == 2'b11) && !m_st;
  assign beat_addr = {base_q, 2'b00} + ADDR_STRIDE * 32'(cnt_q);

  assign mem_load_o   = mem_bus.dmem_rdata;
  assign mem_matrix_o = matrix_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    buf_d     = buf_q;
    matrix_d  = matrix_q;

    mem_bus.dmem_addr  = beat_addr;
    mem_bus.dmem_wdata = me_regs_data2;
    mem_bus.dmem_we    = 1'b0;
    mem_bus.dmem_re    = 1'b0;
    mem_bus.dmem_size  = 3'b010;
    mem_matrix_vld     = 1'b0;
    mem_stall          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m_st) begin
          mem_bus.dmem_addr  = {me_alu_o[31:2], 2'b00};
          mem_bus.dmem_wdata = me_matrix_o[31:0];
          mem_bus.dmem_we    = 1'b1;
          mem_stall          = 1'b1;
          base_d             = me_alu_o[31:2];
          cnt_d              = 3'd1;
          state_d            = MSTORE;
        end else if (m_ld) begin
          mem_bus.dmem_addr  = {me_alu_o[31:2], 2'b00};
          mem_bus.dmem_re    = 1'b1;
          mem_stall          = 1'b1;
          base_d             = me_alu_o[31:2];
          cnt_d              = 3'd1;
          state_d            = MLOAD;
        end else begin
          mem_bus.dmem_addr  = me_alu_o;
          mem_bus.dmem_wdata = me_regs_data2;
          mem_bus.dmem_we    = me_mem_write;
          mem_bus.dmem_re    = me_mem_read;
          mem_bus.dmem_size  = me_func3_code;
        end
      end

      MLOAD: begin
        mem_stall = 1'b1;
        // Read data arriving now belongs to the beat issued last cycle.
        for (int unsigned i = 0; i < LANES; i++) begin
          if (cnt_q == 3'(i + 1)) buf_d[32*i +: 32] = mem_bus.dmem_rdata;
        end
        if (cnt_q == CNT_LAST_LD) begin
          matrix_d = buf_d;
          cnt_d    = 3'd0;
          state_d  = MDONE;
        end else begin
          mem_bus.dmem_re = 1'b1;
          cnt_d           = cnt_q + 3'd1;
        end
      end

      MSTORE: begin
        mem_bus.dmem_we = 1'b1;
        for (int unsigned i = 0; i < LANES; i++) begin
          if (cnt_q == 3'(i)) mem_bus.dmem_wdata = me_matrix_o[32*i +: 32];
        end
        if (cnt_q == CNT_LAST_ST) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + 3'd1;
        end
      end

      MDONE: begin
        mem_matrix_vld = 1'b1;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Strobes are masked while reset is held so a frozen EX/MEM cannot leak through.
    if (!rstn) begin
      mem_bus.dmem_we = 1'b0;
      mem_bus.dmem_re = 1'b0;
      mem_stall       = 1'b0;
      mem_matrix_vld  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      buf_q    <= '0;
      matrix_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      buf_q    <= buf_d;
      matrix_q <= matrix_d;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Randomized bench for stage_mem against a transaction-level memory model.
module tb_stage_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [31:0]  me_alu_o, me_regs_data2;
  logic [127:0] me_matrix_o;
  logic         me_mem_read, me_mem_write;
  logic [1:0]   me_w_select;
  logic [2:0]   me_func3_code;
  logic [31:0]  mem_load_o;
  logic [127:0] mem_matrix_o;
  logic         mem_matrix_vld, mem_stall;

  stage_mem_if bus();

  stage_mem #(.LANES(4), .ADDR_STRIDE(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .me_alu_o      (me_alu_o),
    .me_regs_data2 (me_regs_data2),
    .me_matrix_o   (me_matrix_o),
    .me_mem_read   (me_mem_read),
    .me_mem_write  (me_mem_write),
    .me_w_select   (me_w_select),
    .me_func3_code (me_func3_code),
    .mem_bus       (bus),
    .mem_load_o    (mem_load_o),
    .mem_matrix_o  (mem_matrix_o),
    .mem_matrix_vld(mem_matrix_vld),
    .mem_stall     (mem_stall)
  );

  int total = 0;
  int bad   = 0;

  // 1 KiB data memory, mirrored across the address space (index = addr[9:2]).
  logic [31:0]  env_mem [256];
  logic [255:0] env_written;
  logic         mem_clr;
  logic [31:0]  ref_mem [256];

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    return {8'hC0, idx, ~idx, 8'h5A};
  endfunction

  always @(posedge clk) begin
    if (mem_clr) env_written <= '0;
    else if (bus.dmem_we) begin
      env_mem[bus.dmem_addr[9:2]]     <= bus.dmem_wdata;
      env_written[bus.dmem_addr[9:2]] <= 1'b1;
    end
    if (bus.dmem_re)
      bus.dmem_rdata <= env_written[bus.dmem_addr[9:2]] ? env_mem[bus.dmem_addr[9:2]]
                                                         : init_word(bus.dmem_addr[9:2]);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    me_mem_read   = 1'b0;
    me_mem_write  = 1'b0;
    me_w_select   = 2'($urandom_range(0, 3));
    me_alu_o      = $urandom;
    me_regs_data2 = $urandom;
    me_matrix_o   = {$urandom, $urandom, $urandom, $urandom};
    me_func3_code = 3'($urandom_range(0, 7));
  endtask

  task automatic idle_cycle();
    set_idle();
    #3;
    chk("idle_we", bus.dmem_we, 0);
    chk("idle_re", bus.dmem_re, 0);
    chk("idle_stall", mem_stall, 0);
    chk("idle_vld", mem_matrix_vld, 0);
    chk("idle_addr", bus.dmem_addr, me_alu_o);
    next_cycle();
  endtask

  task automatic scalar_sw(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3, input logic [1:0] ws);
    me_alu_o = a; me_regs_data2 = d; me_func3_code = f3; me_w_select = ws;
    me_mem_write = 1'b1; me_mem_read = 1'b0;
    #3;
    chk("sw_we", bus.dmem_we, 1);
    chk("sw_re", bus.dmem_re, 0);
    chk("sw_addr", bus.dmem_addr, a);
    chk("sw_wdata", bus.dmem_wdata, d);
    chk("sw_size", bus.dmem_size, f3);
    chk("sw_stall", mem_stall, 0);
    ref_mem[a[9:2]] = d;
    next_cycle();
    set_idle();
  endtask

  task automatic scalar_lw(input logic [31:0] a, input logic [2:0] f3, input logic [1:0] ws);
    logic [31:0] want;
    me_alu_o = a; me_func3_code = f3; me_w_select = ws;
    me_mem_read = 1'b1; me_mem_write = 1'b0;
    want = ref_mem[a[9:2]];
    #3;
    chk("lw_re", bus.dmem_re, 1);
    chk("lw_we", bus.dmem_we, 0);
    chk("lw_addr", bus.dmem_addr, a);
    chk("lw_size", bus.dmem_size, f3);
    chk("lw_stall", mem_stall, 0);
    next_cycle();
    set_idle();
    #3;
    chk("lw_data", mem_load_o, want);
    chk("lw_stall_after", mem_stall, 0);
    next_cycle();
  endtask

  task automatic mat_load(input logic [31:0] base, output logic [127:0] want);
    logic [31:0] ab, a;
    ab = {base[31:2], 2'b00};
    me_alu_o = base; me_w_select = 2'b11;
    me_mem_read = 1'b1; me_mem_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = ab + 32'(4 * i);
      want[32*i +: 32] = ref_mem[a[9:2]];
      #3;
      chk("ld_re", bus.dmem_re, 1);
      chk("ld_we", bus.dmem_we, 0);
      chk("ld_addr", bus.dmem_addr, a);
      chk("ld_size", bus.dmem_size, 3'b010);
      chk("ld_stall", mem_stall, 1);
      chk("ld_vld", mem_matrix_vld, 0);
      next_cycle();
    end
    #3;
    chk("ld_tail_re", bus.dmem_re, 0);
    chk("ld_tail_stall", mem_stall, 1);
    chk("ld_tail_vld", mem_matrix_vld, 0);
    next_cycle();
    #3;
    chk("ld_done_vld", mem_matrix_vld, 1);
    chk("ld_done_stall", mem_stall, 0);
    chk("ld_done_re", bus.dmem_re, 0);
    chk("ld_done_we", bus.dmem_we, 0);
    chk("ld_done_data", mem_matrix_o, want);
    next_cycle();
    set_idle();
  endtask

  task automatic mat_store(input logic [31:0] base, input logic [127:0] data, input logic both);
    logic [31:0] ab, a;
    ab = {base[31:2], 2'b00};
    me_alu_o = base; me_matrix_o = data; me_w_select = 2'b11;
    me_mem_write = 1'b1; me_mem_read = both;
    for (int i = 0; i < 4; i++) begin
      a = ab + 32'(4 * i);
      #3;
      chk("st_we", bus.dmem_we, 1);
      chk("st_re", bus.dmem_re, 0);
      chk("st_addr", bus.dmem_addr, a);
      chk("st_wdata", bus.dmem_wdata, data[32*i +: 32]);
      chk("st_size", bus.dmem_size, 3'b010);
      chk("st_stall", mem_stall, (i < 3) ? 1 : 0);
      chk("st_vld", mem_matrix_vld, 0);
      ref_mem[a[9:2]] = data[32*i +: 32];
      next_cycle();
    end
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got_exp, sdata;
    logic [31:0]  base;
    logic [1:0]   ws;
    int unsigned  op;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    rstn = 1'b0;
    mem_clr = 1'b1;
    set_idle();
    me_mem_read = 1'b1; me_mem_write = 1'b1; me_w_select = 2'b00;
    #2;
    chk("rst_stall", mem_stall, 0);
    chk("rst_we", bus.dmem_we, 0);
    chk("rst_re", bus.dmem_re, 0);
    chk("rst_vld", mem_matrix_vld, 0);
    chk("rst_matrix", mem_matrix_o, 0);
    @(posedge clk); @(posedge clk); #1;
    mem_clr = 1'b0;
    set_idle();
    rstn = 1'b1;

    // T1: scalar store/load
    scalar_sw(32'h100, 32'hDEADBEEF, 3'b010, 2'b00);
    idle_cycle();
    scalar_lw(32'h100, 3'b010, 2'b01);

    // T2: matrix load of known words
    for (int i = 0; i < 4; i++) scalar_sw(32'h200 + 32'(4 * i), 32'h11 * 32'(i + 1), 3'b010, 2'b00);
    mat_load(32'h200, got_exp);
    chk("t2_matrix", mem_matrix_o, 128'h00000044_00000033_00000022_00000011);

    // T3: unaligned matrix store
    mat_store(32'h30F, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0);
    scalar_lw(32'h318, 3'b010, 2'b00);

    // T4: wrapping matrix load
    mat_load(32'hFFFF_FFF8, got_exp);

    // T5: reset during MLOAD beat 2
    me_alu_o = 32'h400; me_w_select = 2'b11; me_mem_read = 1'b1; me_mem_write = 1'b0;
    next_cycle();
    next_cycle();
    #2 rstn = 1'b0;
    #1;
    chk("t5_stall", mem_stall, 0);
    chk("t5_re", bus.dmem_re, 0);
    chk("t5_matrix", mem_matrix_o, 0);
    chk("t5_vld", mem_matrix_vld, 0);
    @(posedge clk); #1;
    chk("t5_matrix_held", mem_matrix_o, 0);
    set_idle();
    #1 rstn = 1'b1;
    scalar_sw(32'h404, 32'hCAFE_F00D, 3'b010, 2'b00);
    scalar_lw(32'h404, 3'b010, 2'b00);

    // T6: back-to-back store then load of the same matrix
    sdata = {$urandom, $urandom, $urandom, $urandom};
    mat_store(32'h040, sdata, 1'b1);
    mat_load(32'h040, got_exp);
    chk("t6_roundtrip", mem_matrix_o, sdata);
    idle_cycle();

    repeat (40) begin
      op   = $urandom_range(0, 4);
      base = 32'($urandom_range(0, 63)) << 4;
      base = base + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) base = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      ws = 2'($urandom_range(0, 2));
      case (op)
        0: scalar_sw(base, $urandom, 3'($urandom_range(0, 7)), ws);
        1: scalar_lw(base, 3'($urandom_range(0, 7)), ws);
        2: mat_load(base, got_exp);
        3: mat_store(base, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        default: idle_cycle();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
